// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for edge_synth and its dwell counter:
//   - state_e      : 2-bit FSM state encoding
//   - DEF_MIN_HIGH : default minimum high dwell, in cycles
//   - DEF_MIN_LOW  : default minimum low dwell, in cycles
//   - DEF_CNT_W    : default dwell counter width
//   - state_is_high: 1 for the states in which `level` is 1
// -----------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    HOLD_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    HOLD_LOW  = 2'd3
  } state_e;

  localparam int DEF_MIN_HIGH = 4;
  localparam int DEF_MIN_LOW  = 4;
  localparam int DEF_CNT_W    = 8;

  function automatic logic state_is_high(input state_e s);
    return (s == HOLD_HIGH) || (s == IDLE_HIGH);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Loadable down-counter that times the HOLD_HIGH / HOLD_LOW dwells.
// It stops at zero instead of wrapping.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-low reset (count cleared to 0)
//   load     in  load load_val this cycle (takes priority over en)
//   load_val in  CNT_W-bit value to load
//   en       in  decrement by one if the count is not already zero
//   zero     out count is zero
// -----------------------------------------------------------------------------
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/edge_synth.sv
// -----------------------------------------------------------------------------
// edge_synth
// Turns single-cycle rise/fall request pulses into a clean registered level.
// After each edge, the level is held for a minimum dwell time. One
// opposite-direction request that arrives during a dwell is queued and
// applied when the dwell ends.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-low reset
//   rise_req in  one-cycle request to drive level high
//   fall_req in  one-cycle request to drive level low
//   level    out registered synthesized level
//   busy     out a dwell (HOLD_HIGH / HOLD_LOW) is in progress
//   rise_ack out pulse in the first cycle level is 1
//   fall_ack out pulse in the first cycle level is 0 after a fall
//   drop_err out pulse one cycle after a request is discarded as a conflict
// -----------------------------------------------------------------------------
module edge_synth
  import edge_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MIN_LOW  = DEF_MIN_LOW,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic rise_req,
  input  logic fall_req,
  output logic level,
  output logic busy,
  output logic rise_ack,
  output logic fall_ack,
  output logic drop_err
);

  // The counter is loaded with N-1 on entry to a dwell. The dwell then lasts
  // N cycles, and its last cycle is the one in which the count is zero.
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             pend_eff;
  logic             opp_req, same_req;
  logic             rise_ack_d, fall_ack_d, drop_err_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE_LOW;
      pend_q   <= 1'b0;
      level    <= 1'b0;
      busy     <= 1'b0;
      rise_ack <= 1'b0;
      fall_ack <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      level    <= state_is_high(state_d);
      busy     <= (state_d == HOLD_HIGH) || (state_d == HOLD_LOW);
      rise_ack <= rise_ack_d;
      fall_ack <= fall_ack_d;
      drop_err <= drop_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_eff     = pend_q;
    rise_ack_d   = 1'b0;
    fall_ack_d   = 1'b0;
    drop_err_d   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    // Classify the request relative to the current level. This lets both
    // HOLD states share one branch.
    opp_req      = state_is_high(state_q) ? fall_req : rise_req;
    same_req     = state_is_high(state_q) ? rise_req : fall_req;

    if (rise_req && fall_req) begin
      // Simultaneous requests are discarded. State, pend and count all
      // freeze, which can leave a HOLD at count zero so that the exit is
      // evaluated again next cycle.
      drop_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE_LOW: begin
          if (rise_req) begin
            state_d      = HOLD_HIGH;
            rise_ack_d   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = HIGH_LOAD;
          end
        end

        IDLE_HIGH: begin
          if (fall_req) begin
            state_d      = HOLD_LOW;
            fall_ack_d   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = LOW_LOAD;
          end
        end

        HOLD_HIGH, HOLD_LOW: begin
          // An opposite request queues a reversal. A repeat of the current
          // direction cancels a queued reversal and reports it as dropped.
          if (opp_req) begin
            pend_eff = 1'b1;
          end else if (same_req && pend_q) begin
            pend_eff   = 1'b0;
            drop_err_d = 1'b1;
          end
          pend_d = pend_eff;

          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else if (pend_eff) begin
            pend_d   = 1'b0;
            cnt_load = 1'b1;
            if (state_q == HOLD_HIGH) begin
              state_d      = HOLD_LOW;
              fall_ack_d   = 1'b1;
              cnt_load_val = LOW_LOAD;
            end else begin
              state_d      = HOLD_HIGH;
              rise_ack_d   = 1'b1;
              cnt_load_val = HIGH_LOAD;
            end
          end else begin
            state_d = (state_q == HOLD_HIGH) ? IDLE_HIGH : IDLE_LOW;
          end
        end

        default: state_d = IDLE_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_synth.sv
// -----------------------------------------------------------------------------
// tb_edge_synth
// Self-checking bench for edge_synth. A behavioural model tracks the level,
// the cycles left in the current dwell and a queued reversal. A compare
// process checks every DUT output against the model on each falling edge.
// Directed scenarios add literal expectations. A bench-side edge detector
// closes the round trip.
// -----------------------------------------------------------------------------
module tb_edge_synth;

  localparam int MIN_HIGH = 4;
  localparam int MIN_LOW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rise_req = 1'b0;
  logic fall_req = 1'b0;
  logic level, busy, rise_ack, fall_ack, drop_err;

  int tests = 0;
  int fails = 0;

  edge_synth #(.MIN_HIGH(MIN_HIGH), .MIN_LOW(MIN_LOW), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rise_req (rise_req),
    .fall_req (fall_req),
    .level    (level),
    .busy     (busy),
    .rise_ack (rise_ack),
    .fall_ack (fall_ack),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // left = cycles of dwell remaining, counting the current one (0 = idle).
  typedef struct packed {
    logic level;
    logic pend;
    int   left;
    logic rack;
    logic fack;
    logic drop;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur, input logic r, input logic f);
    model_t n;
    logic flip;
    logic want_high;
    n = cur;
    n.rack = 1'b0;
    n.fack = 1'b0;
    n.drop = 1'b0;
    flip = 1'b0;
    if (r && f) begin
      n.drop = 1'b1;
    end else begin
      if (r || f) begin
        want_high = r;
        if (cur.left == 0) flip = (want_high != cur.level);
        else if (want_high != cur.level) n.pend = 1'b1;
        else if (cur.pend) begin
          n.pend = 1'b0;
          n.drop = 1'b1;
        end
      end
      if (cur.left == 1) begin
        flip = n.pend;
        if (!flip) n.left = 0;
      end else if (cur.left > 1) begin
        n.left = cur.left - 1;
      end
    end
    if (flip) begin
      n.level = !cur.level;
      n.left  = n.level ? MIN_HIGH : MIN_LOW;
      n.pend  = 1'b0;
      n.rack  = n.level;
      n.fack  = !n.level;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_next(m, rise_req, fall_req);
  end

  // Stand-in for the downstream edge_detection block
  logic prev_level;
  always @(posedge clk or negedge rst) begin
    if (!rst) prev_level <= 1'b0;
    else      prev_level <= level;
  end
  wire enable_rise = level & ~prev_level;
  wire enable_fall = ~level & prev_level;

  int n_rack = 0, n_fack = 0, n_en_rise = 0, n_en_fall = 0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("level", level, m.level);
    check("busy", busy, (m.left > 0));
    check("rise_ack", rise_ack, m.rack);
    check("fall_ack", fall_ack, m.fack);
    check("drop_err", drop_err, m.drop);
    check("ack_excl", rise_ack & fall_ack, 1'b0);
    n_rack    += int'(rise_ack);
    n_fack    += int'(fall_ack);
    n_en_rise += int'(enable_rise);
    n_en_fall += int'(enable_fall);
  end

  // Apply r/f for one cycle. On return the outputs hold the result of that edge.
  task automatic cyc(input logic r, input logic f);
    rise_req = r;
    fall_req = f;
    @(posedge clk);
    #1;
    rise_req = 1'b0;
    fall_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset, then a basic rise
    #10;
    check("rst_level", level, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {rise_ack, fall_ack, drop_err}, 3'b000);
    #12 rst = 1'b1;
    idle(3);
    cyc(1'b1, 1'b0);
    check("s1_level", level, 1'b1);
    check("s1_rise_ack", rise_ack, 1'b1);
    check("s1_busy_first", busy, 1'b1);
    idle(3);
    check("s1_busy_last", busy, 1'b1);
    check("s1_ack_width", rise_ack, 1'b0);
    idle(1);
    check("s1_idle_high_busy", busy, 1'b0);
    check("s1_idle_high_level", level, 1'b1);
    cyc(1'b0, 1'b1);
    check("s1_fall_ack", fall_ack, 1'b1);
    idle(5);

    // 2. Fall queued during the high dwell
    cyc(1'b1, 1'b0);                 // request in cycle 5, dwell cycles 6..9
    idle(1);
    cyc(1'b0, 1'b1);                 // fall request in cycle 7
    check("s2_c8_level", level, 1'b1);
    idle(1);
    check("s2_c9_level", level, 1'b1);
    idle(1);
    check("s2_c10_level", level, 1'b0);
    check("s2_c10_fall_ack", fall_ack, 1'b1);
    idle(3);
    check("s2_c13_busy", busy, 1'b1);
    idle(1);
    check("s2_c14_busy", busy, 1'b0);
    idle(2);

    // 3. Conflicts
    cyc(1'b1, 1'b1);
    check("s3_drop", drop_err, 1'b1);
    check("s3_level", level, 1'b0);
    check("s3_no_ack", {rise_ack, fall_ack}, 2'b00);
    idle(1);
    check("s3_drop_width", drop_err, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);                 // queue a fall
    cyc(1'b1, 1'b0);                 // cancel it
    check("s3_cancel_drop", drop_err, 1'b1);
    idle(2);
    check("s3_into_idle_high", {level, busy, fall_ack}, 3'b100);
    cyc(1'b0, 1'b1);
    idle(5);

    // 6. Redundant requests
    cyc(1'b0, 1'b1);
    check("s6_fall_in_low", {level, busy, drop_err}, 3'b000);
    cyc(1'b1, 1'b0);
    check("s6_rise_ack", rise_ack, 1'b1);
    cyc(1'b1, 1'b0);
    check("s6_redundant1", {level, rise_ack, drop_err}, 3'b100);
    cyc(1'b1, 1'b0);
    check("s6_redundant2", {level, rise_ack, drop_err}, 3'b100);
    idle(2);
    check("s6_idle_high", {level, busy}, 2'b10);
    cyc(1'b0, 1'b1);
    idle(5);

    // 4. Reset in the middle of a dwell
    cyc(1'b1, 1'b0);
    idle(1);
    rst = 1'b0;
    #1;
    check("s4_async_level", level, 1'b0);
    check("s4_async_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    cyc(1'b1, 1'b0);
    check("s4_after_rise", {level, rise_ack, busy}, 3'b111);
    idle(4);
    check("s4_after_idle_high", {level, busy}, 2'b10);

    // 5. Round trip with legal, spaced pulses (the level starts high here)
    for (int i = 0; i < 40; i++) begin
      cyc(~level, level);
      check("rt_en_rise", enable_rise, rise_ack);
      check("rt_en_edge", enable_rise | enable_fall, 1'b1);
      idle(((level ? MIN_HIGH : MIN_LOW) - 1) + int'($urandom_range(0, 3)));
    end

    // Randomized traffic, including conflicts and queued or cancelled reversals
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(8);

    check("rt_rise_count", n_en_rise, n_rack);
    check("rt_fall_count", n_en_fall, n_fack);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edge_synth.md
Name: edge_synth

Overview:
- Inverse of the team's edge_detection block: converts single-cycle rise/fall request pulses back into a clean registered level.
- Enforces minimum high and low dwell times, and queues one opposite-direction request that arrives during a dwell.
- Drives enables and strobes that the rest of the design later edge-detects.
- Round-trip check: edge_synth -> edge_detection must reproduce the request pulses, delayed.

Parameters:
- MIN_HIGH, 4: minimum cycles `level` stays 1 after a rise (>=1).
- MIN_LOW, 4: minimum cycles `level` stays 0 after a fall (>=1).
- CNT_W, 8: dwell counter width; must satisfy 2**CNT_W > max(MIN_HIGH, MIN_LOW).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rise_req  in  1  one-cycle request to drive `level` high.
- fall_req  in  1  one-cycle request to drive `level` low.
- level  out  1  registered synthesized level.
- busy  out  1  high while a dwell is in progress (HOLD_HIGH or HOLD_LOW).
- rise_ack  out  1  one-cycle pulse in the first cycle `level` is 1.
- fall_ack  out  1  one-cycle pulse in the first cycle `level` is 0 after a fall.
- drop_err  out  1  one-cycle pulse when a request is discarded as a conflict.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE_LOW, level=0, cnt=0, pend=0.
  - busy, rise_ack, fall_ack and drop_err are all 0.
  - Reset asserted mid-dwell aborts immediately; a pending request is lost.
- States: IDLE_LOW, HOLD_HIGH, IDLE_HIGH, HOLD_LOW. `level` = 1 in HOLD_HIGH and IDLE_HIGH.
- IDLE_LOW:
  - rise_req alone in cycle n -> HOLD_HIGH at n+1.
  - At n+1: level=1, rise_ack=1, cnt=MIN_HIGH-1.
  - Latency is 1 cycle.
- HOLD_HIGH:
  - cnt decrements by 1 each cycle.
  - fall_req sets pend=1.
  - rise_req while pend=0 is redundant: ignored silently.
  - rise_req while pend=1 clears pend and pulses drop_err next cycle.
  - When cnt==0 with pend=1, or with fall_req in that same cycle: go to HOLD_LOW. Next cycle level=0, fall_ack=1, cnt=MIN_LOW-1, pend cleared.
  - When cnt==0 otherwise: go to IDLE_HIGH.
  - Net result: `level` is high for exactly MIN_HIGH cycles when a fall is already queued.
- IDLE_HIGH: mirror of IDLE_LOW. fall_req -> HOLD_LOW, with level=0, fall_ack=1, cnt=MIN_LOW-1 next cycle.
- HOLD_LOW: mirror of HOLD_HIGH. rise_req sets pend; at cnt==0 a pending rise goes to HOLD_HIGH.
- Simultaneous requests:
  - rise_req and fall_req both high in the same cycle, in any state: both ignored, no state or pend change, drop_err pulses next cycle.
  - This takes priority over the cnt==0 exit in that cycle. The state stays in HOLD with cnt held at 0, and the transition is evaluated again next cycle.
- Redundant requests in IDLE states (rise_req in IDLE_HIGH, fall_req in IDLE_LOW): ignored, no error.
- busy: 1 exactly in HOLD_HIGH and HOLD_LOW.
- Output registration: all outputs registered. rise_ack and fall_ack never both 1; each is at most 1 cycle wide.
- Counter: cnt saturates at 0 and never wraps.

Decomposition:
- Shared package edge_pkg:
  - State encoding constants (2 bits: IDLE_LOW=0, HOLD_HIGH=1, IDLE_HIGH=2, HOLD_LOW=3).
  - Default MIN_HIGH and MIN_LOW constants.
- One natural sub-module, dwell_counter:
  - Loadable down-counter, CNT_W wide.
  - Inputs: load, load_val, en.
  - Output: zero flag.
  - Saturates at 0.
- The FSM, pend flag and output registers live in edge_synth.

Test Plan:
1. Reset and basic rise:
   - Stimulus: rst=0 for 22 ns, release; rise_req pulse at cycle 5.
   - Response: level=0 and all strobes 0 during reset. level=1 and rise_ack=1 at cycle 6. busy=1 for cycles 6–9 (MIN_HIGH=4), then IDLE_HIGH.
2. Queued fall:
   - Stimulus: rise_req at cycle 5, fall_req at cycle 7.
   - Response: level high for exactly cycles 6–9; level=0 and fall_ack=1 at cycle 10; busy stays 1 through cycle 13.
3. Conflict:
   - Stimulus: rise_req and fall_req together at cycle 5 in IDLE_LOW.
   - Response: drop_err=1 at cycle 6; level stays 0; no ack.
   - Also: in HOLD_HIGH with pend=1, a rise_req gives drop_err the next cycle, and level remains high into IDLE_HIGH.
4. Reset mid-dwell:
   - Stimulus: rise_req at cycle 5, rst=0 at cycle 7.
   - Response: level=0 and busy=0 immediately (asynchronous); after release, a rise_req behaves as in scenario 1.
5. Round trip:
   - Stimulus: connect level to edge_detection; issue random legal rise/fall pulses spaced >= MIN_HIGH/MIN_LOW apart.
   - Response: enable_rise and enable_fall follow each accepted request at a fixed latency; counts of rise_ack equal enable_rise and fall_ack equal enable_fall.
6. Redundant requests:
   - Stimulus: fall_req in IDLE_LOW, then rise_req twice during HOLD_HIGH with pend=0.
   - Response: no state change, no drop_err, single rise_ack.
